// File: rtl/butterfly_inverse_engine_if.sv
// Port bundle for butterfly_inverse_engine: start/done control, the shared RAM
// port-A read address/data, the shared port-B write bus, the checksum and the FSM state.
interface butterfly_inverse_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);
  // Handshake: start is sampled only while idle (state_dbg == 0). busy is high for the
  // whole streaming pass, and done pulses for exactly one cycle once the last write has
  // been issued. Any start seen while busy or done is high is dropped, not queued.
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] read_data_0;
  logic [DATA_W-1:0] read_data_1;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data_0;
  logic [DATA_W-1:0] write_data_1;
  logic              write_enable;
  logic [DATA_W-1:0] checksum;
  logic [1:0]        state_dbg;

  modport master (
    output start, read_data_0, read_data_1,
    input  busy, done, read_address, write_address, write_data_0, write_data_1,
           write_enable, checksum, state_dbg
  );

  modport slave (
    input  start, read_data_0, read_data_1,
    output busy, done, read_address, write_address, write_data_0, write_data_1,
           write_enable, checksum, state_dbg
  );
endinterface

// File: rtl/butterfly_inverse_engine.sv
// Inverse sum/difference butterfly: streams (Y,Z) pairs from two RAMs and writes
// W=(Y+Z)/2 back to RAM0 and X=(Y-Z)/2 back to RAM1 in place, one pair per cycle.
module butterfly_inverse_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input logic                      CLOCK_50_I,
  input logic                      resetn,
  butterfly_inverse_engine_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] read_address_r;
  logic [ADDR_W-1:0] write_address_r;
  logic              write_enable_r;
  logic [DATA_W-1:0] checksum_r;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              last_read;
  logic              busy_c;
  logic              done_c;
  logic              unused_lsbs;

  assign last_read = (read_address_r == LAST_ADDR);

  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_RUN;
      S_RUN: begin
        busy_c = 1'b1;
        if (last_read) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy_c     = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done_c     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The write side trails the read side by exactly one cycle to match the RAM read
  // latency, so port B always writes address k while port A fetches k+1.
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      read_address_r  <= '0;
      write_address_r <= '0;
      write_enable_r  <= 1'b0;
      checksum_r      <= '0;
    end else begin
      write_enable_r <= (state == S_RUN);
      if (write_enable_r) checksum_r <= checksum_r ^ bus.write_data_0 ^ bus.write_data_1;
      case (state)
        S_IDLE: if (bus.start) begin
          read_address_r <= '0;
          checksum_r     <= '0;
        end
        S_RUN: begin
          write_address_r <= read_address_r;
          if (!last_read) read_address_r <= read_address_r + ADDR_W'(1);
        end
        S_DONE:  read_address_r <= '0;
        default: ;
      endcase
    end
  end

  // Zero-extended operands; the borrow of diff lands in the top bit, so dropping the
  // LSB gives a floor halve for both the unsigned sum and the signed difference.
  assign sum         = {1'b0, bus.read_data_0} + {1'b0, bus.read_data_1};
  assign diff        = {1'b0, bus.read_data_0} - {1'b0, bus.read_data_1};
  assign unused_lsbs = sum[0] ^ diff[0];

  assign bus.write_data_0  = sum[DATA_W:1];
  assign bus.write_data_1  = diff[DATA_W:1];
  assign bus.read_address  = read_address_r;
  assign bus.write_address = write_address_r;
  assign bus.write_enable  = write_enable_r;
  assign bus.checksum      = checksum_r;
  assign bus.busy          = busy_c;
  assign bus.done          = done_c;
  assign bus.state_dbg     = state;
endmodule

// File: tb/tb_butterfly_inverse_engine.sv
// Bench for butterfly_inverse_engine: two behavioural dual-port RAMs, an arithmetic
// reference model, a negedge monitor and a linear sequence of directed/random passes.
module tb_butterfly_inverse_engine;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #10 clk = ~clk;

  butterfly_inverse_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  butterfly_inverse_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLOCK_50_I (clk),
    .resetn     (resetn),
    .bus        (bus)
  );

  // Behavioural RAMs: registered port-A read, port-B write.
  logic [DATA_W-1:0] ram0 [DEPTH];
  logic [DATA_W-1:0] ram1 [DEPTH];
  logic [DATA_W-1:0] init0 [DEPTH];
  logic [DATA_W-1:0] init1 [DEPTH];
  logic [DATA_W-1:0] rd0 = '0;
  logic [DATA_W-1:0] rd1 = '0;

  always @(posedge clk) begin
    rd0 <= ram0[bus.read_address];
    rd1 <= ram1[bus.read_address];
    if (bus.write_enable) begin
      ram0[bus.write_address] = bus.write_data_0;
      ram1[bus.write_address] = bus.write_data_1;
    end
  end
  assign bus.read_data_0 = rd0;
  assign bus.read_data_1 = rd1;

  // Monitor, sampled on the falling edge.
  int                cyc_n = 0;
  int                wr_cnt = 0;
  int                busy_cnt = 0;
  int                c0 = 0;
  logic [ADDR_W-1:0] wa_q [$];
  logic [ADDR_W-1:0] pra_q [$];
  int                done_q [$];
  logic [ADDR_W-1:0] prev_ra = '0;

  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (bus.write_enable === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      wa_q.push_back(bus.write_address);
      pra_q.push_back(prev_ra);
    end
    if (bus.busy === 1'b1) busy_cnt = busy_cnt + 1;
    if (bus.done === 1'b1) done_q.push_back(cyc_n);
    prev_ra = bus.read_address;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic with floor division.
  function automatic logic [DATA_W-1:0] model_w(input int y, input int z);
    return DATA_W'((y + z) / 2);
  endfunction

  function automatic logic [DATA_W-1:0] model_x(input int y, input int z);
    int d;
    d = y - z;
    if (d < 0 && (d % 2) != 0) d = d - 1;
    return DATA_W'(d / 2);
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < DEPTH; k++) begin
      case (mode)
        0: begin ram0[k] = 8'd100; ram1[k] = 8'd40; end
        2: begin ram0[k] = DATA_W'(k); ram1[k] = '0; end
        default: begin
          ram0[k] = DATA_W'($urandom_range(0, 255));
          ram1[k] = DATA_W'($urandom_range(0, 255));
        end
      endcase
      init0[k] = ram0[k];
      init1[k] = ram1[k];
    end
  endtask

  task automatic clear_mon();
    wr_cnt   = 0;
    busy_cnt = 0;
    wa_q.delete();
    pra_q.delete();
    done_q.delete();
  endtask

  // One pass on a fixed timeline. poke pulses start at cycle 10 and on the done cycle;
  // abort_at > 0 asserts reset in that cycle and returns one cycle later, reset still low.
  task automatic run_pass(input int abort_at, input bit poke);
    clear_mon();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    c0 = cyc_n;
    for (int c = 2; c <= DEPTH + 2; c++) begin
      @(posedge clk); #1;
      bus.start = poke && (c == 10 || c == DEPTH + 2);
      if (abort_at > 0 && c == abort_at) begin
        resetn = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_addrs(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] !== ADDR_W'(i)) bad++;
      if (pra_q[i] !== wa_q[i]) bad++;
    end
    check({tag, "_addr_order"}, bad, 0);
  endtask

  task automatic verify_ram(input string tag, input int n_wr, output logic [DATA_W-1:0] cs);
    int bad0, bad1;
    logic [DATA_W-1:0] ew, ex;
    bad0 = 0;
    bad1 = 0;
    cs   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < n_wr) begin
        ew = model_w(int'(init0[k]), int'(init1[k]));
        ex = model_x(int'(init0[k]), int'(init1[k]));
        cs = cs ^ ew ^ ex;
      end else begin
        ew = init0[k];
        ex = init1[k];
      end
      if (ram0[k] !== ew) bad0++;
      if (ram1[k] !== ex) bad1++;
    end
    check({tag, "_ram0_bad_words"}, bad0, 0);
    check({tag, "_ram1_bad_words"}, bad1, 0);
  endtask

  task automatic check_pass(input string tag);
    logic [DATA_W-1:0] cs_exp;
    check({tag, "_wr_count"}, wr_cnt, DEPTH);
    check({tag, "_busy_cycles"}, busy_cnt, DEPTH + 1);
    check({tag, "_done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) check({tag, "_done_latency"}, done_q[0] - c0, DEPTH + 2);
    check_addrs(tag);
    verify_ram(tag, DEPTH, cs_exp);
    check({tag, "_checksum"}, bus.checksum, cs_exp);
    check({tag, "_idle_state"}, bus.state_dbg, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] cs_exp;
    int bad;

    // Reset held three cycles with start high.
    bus.start = 1'b1;
    resetn    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wren", bus.write_enable, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_checksum", bus.checksum, 0);
    check("rst_state", bus.state_dbg, 0);
    check("rst_read_addr", bus.read_address, 0);
    check("rst_write_addr", bus.write_address, 0);
    bus.start = 1'b0;
    resetn    = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", bus.state_dbg, 0);

    // Constant data pass; equal terms cancel in the checksum.
    fill(0);
    run_pass(0, 1'b0);
    check_pass("const");
    check("const_ram0_k0", ram0[0], 70);
    check("const_ram1_k511", ram1[DEPTH-1], 30);
    check("const_checksum_zero", bus.checksum, 0);

    // Random data with sign/rounding corner pairs planted.
    fill(1);
    ram0[5] = 8'd40;  ram1[5] = 8'd100;
    ram0[6] = 8'd255; ram1[6] = 8'd255;
    ram0[7] = 8'd0;   ram1[7] = 8'd255;
    for (int k = 5; k <= 7; k++) begin
      init0[k] = ram0[k];
      init1[k] = ram1[k];
    end
    run_pass(0, 1'b0);
    check_pass("rand_corner");
    check("corner_w_40_100", ram0[5], 70);
    check("corner_x_40_100", ram1[5], 8'hE2);
    check("corner_w_255_255", ram0[6], 255);
    check("corner_x_255_255", ram1[6], 0);
    check("corner_w_0_255", ram0[7], 127);
    check("corner_x_0_255", ram1[7], 8'h80);

    // Addressing pattern: word k holds its own low address bits.
    fill(2);
    run_pass(0, 1'b0);
    check_pass("addr");
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ram0[k] !== DATA_W'((k & 255) >> 1)) bad++;
      if (ram1[k] !== DATA_W'((k & 255) >> 1)) bad++;
    end
    check("addr_halved_words", bad, 0);

    // start pulsed mid-pass and on the done cycle must be ignored.
    fill(1);
    run_pass(0, 1'b1);
    check_pass("ignore_start");
    fill(1);
    run_pass(0, 1'b0);
    check_pass("second_pass");

    // Reset in cycle 200 aborts the pass.
    fill(1);
    run_pass(200, 1'b0);
    check("abort_wren", bus.write_enable, 0);
    check("abort_state", bus.state_dbg, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_checksum", bus.checksum, 0);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_wr_count", wr_cnt, 199);
    check("abort_done_count", done_q.size(), 0);
    check_addrs("abort");
    verify_ram("abort", 199, cs_exp);
    check("abort_idle_state", bus.state_dbg, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
